if_stage: RTL and testbench

- Instruction-fetch stage (pre-IF + IF) of the 5-stage LoongArch pipeline.
- Generates the next PC, drives the synchronous instruction SRAM, and holds the fetched instruction.
- Delivers {pc, inst} to the decode stage over the valid/allowin handshake.
- Consumes the decode stage's branch-redirect bus {br_taken, br_target}, i.e. it is the producer end of if_to_id and the consumer end of id_to_if.

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage (pre-IF + IF): next-PC selection, instruction SRAM request, IF holding register.
// Optional misaligned-fetch detection is enabled by defining IF_ADEF_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  input  logic [32:0] id_to_if_bus,
  output logic        if_to_id_valid,
  output logic [63:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_adef
);

  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  logic        br_taken;
  logic [31:0] br_target;

  logic [31:0] if_pc_reg;
  logic        if_valid_reg;
  logic        br_pend_reg;
  logic [31:0] br_pend_target_reg;
  logic [31:0] inst_buf_reg;
  logic        inst_buf_valid_reg;

  logic        to_if_valid;
  logic        if_ready_go;
  logic        if_allowin;
  logic [31:0] nextpc;
  logic        fetch_adef;
  logic [31:0] raw_inst;
  logic [31:0] if_inst;

  assign {br_taken, br_target} = id_to_if_bus;

  // Pre-IF always has a request pending while out of reset.
  assign to_if_valid = resetn;
  assign if_ready_go = 1'b1;
  assign if_allowin  = ~if_valid_reg | (if_ready_go & id_allowin);

  always_comb begin
    nextpc = if_pc_reg + 32'd4;
    if (br_taken) begin
      nextpc = br_target;
    end else if (br_pend_reg) begin
      nextpc = br_pend_target_reg;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  assign fetch_adef = |nextpc[1:0];
`else
  assign fetch_adef = 1'b0;
`endif

  assign inst_sram_en    = to_if_valid & if_allowin & ~fetch_adef;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_pc_reg          <= RESET_PC - 32'd4;
      if_valid_reg       <= 1'b0;
      br_pend_reg        <= 1'b0;
      br_pend_target_reg <= 32'h0000_0000;
    end else if (if_allowin) begin
      if_valid_reg <= to_if_valid;
      if_pc_reg    <= nextpc;
      br_pend_reg  <= 1'b0;
    end else if (br_taken) begin
      // IF cannot advance: kill the wrong-path slot and remember where to go.
      if_valid_reg       <= 1'b0;
      br_pend_reg        <= 1'b1;
      br_pend_target_reg <= br_target;
    end
  end

  // SRAM data is only valid one cycle after the request, so park it during a stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf_reg       <= 32'h0000_0000;
      inst_buf_valid_reg <= 1'b0;
    end else if (if_allowin || br_taken) begin
      inst_buf_valid_reg <= 1'b0;
    end else if (if_valid_reg && !inst_buf_valid_reg && !id_allowin) begin
      inst_buf_reg       <= inst_sram_rdata;
      inst_buf_valid_reg <= 1'b1;
    end
  end

  assign raw_inst = inst_buf_valid_reg ? inst_buf_reg : inst_sram_rdata;

`ifdef IF_ADEF_CHECK_EN
  logic if_adef_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_adef_reg <= 1'b0;
    end else if (if_allowin) begin
      if_adef_reg <= fetch_adef;
    end
  end

  assign if_adef = if_adef_reg & if_valid_reg;
  assign if_inst = if_adef_reg ? NOP_INST : raw_inst;
`else
  assign if_adef = 1'b0;
  assign if_inst = raw_inst;
`endif

  assign if_to_id_valid = if_valid_reg & if_ready_go & ~br_taken;
  assign if_to_id_bus   = {if_pc_reg, if_inst};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus hand-written reset and misalignment sequences.
module tb_if_stage;

  logic        clk;
  logic        resetn;
  logic        id_allowin;
  logic [32:0] id_to_if_bus;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        if_adef;

  int tests_run;
  int tests_failed;

  if_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_allowin      (id_allowin),
    .id_to_if_bus    (id_to_if_bus),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .if_adef         (if_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM returns its address as data; garbage when not enabled so stale reads are visible.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? inst_sram_addr : 32'hdead_beef;
  end

  typedef struct {
    logic        ia;
    logic        bt;
    logic [31:0] tgt;
    logic        e_vld;
    logic        e_en;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            ia    bt    tgt           vld   en    addr          pc            inst
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000000, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000004, 32'h1c000000, 32'h1c000000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000008, 32'h1c000004, 32'h1c000004};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c00000c, 32'h1c000008, 32'h1c000008};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c00000c, 32'h1c000008, 32'h1c000008};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c00000c, 32'h1c000008, 32'h1c000008};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c00000c, 32'h1c000008, 32'h1c000008};
    vecs[7]  = '{1'b1, 1'b1, 32'h1c000100, 1'b0, 1'b1, 32'h1c000100, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000104, 32'h1c000100, 32'h1c000100};
    vecs[9]  = '{1'b0, 1'b1, 32'h1c000200, 1'b0, 1'b0, 32'h1c000200, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000200, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c000204, 32'h1c000200, 32'h1c000200};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000204, 32'h1c000200, 32'h1c000200};
    vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000208, 32'h1c000204, 32'h1c000204};
    vecs[14] = '{1'b1, 1'b1, 32'hfffffffc, 1'b0, 1'b1, 32'hfffffffc, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 32'hfffffffc, 32'hfffffffc};
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000004, 32'h00000000, 32'h00000000};

    resetn       = 1'b0;
    id_allowin   = 1'b0;
    id_to_if_bus = 33'h0;

    repeat (3) @(posedge clk);
    #4;
    chk("reset_valid", {63'h0, if_to_id_valid}, 64'h0);
    chk("reset_en",    {63'h0, inst_sram_en},   64'h0);
    chk("reset_adef",  {63'h0, if_adef},        64'h0);
    chk("reset_pc",    {32'h0, if_to_id_bus[63:32]}, {32'h0, 32'h1bfffffc});
    chk("const_we_wdata", {28'h0, inst_sram_we, inst_sram_wdata}, 64'h0);

    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) resetn = 1'b1;
      id_allowin   = vecs[i].ia;
      id_to_if_bus = {vecs[i].bt, vecs[i].tgt};
      #3;
      chk($sformatf("v%0d_valid", i), {63'h0, if_to_id_valid}, {63'h0, vecs[i].e_vld});
      chk($sformatf("v%0d_en", i),    {63'h0, inst_sram_en},   {63'h0, vecs[i].e_en});
      chk($sformatf("v%0d_addr", i),  {32'h0, inst_sram_addr}, {32'h0, vecs[i].e_addr});
      chk($sformatf("v%0d_adef", i),  {63'h0, if_adef},        64'h0);
      if (vecs[i].e_vld)
        chk($sformatf("v%0d_bus", i), if_to_id_bus, {vecs[i].e_pc, vecs[i].e_inst});
      $display("[TB] vec %0d ia=%0b bt=%0b vld=%0b en=%0b addr=%h bus=%h",
               i, vecs[i].ia, vecs[i].bt, if_to_id_valid, inst_sram_en, inst_sram_addr, if_to_id_bus);
    end

    // Asynchronous reset in the middle of a stall.
    @(posedge clk);
    #1;
    id_allowin   = 1'b0;
    id_to_if_bus = 33'h0;
    #3;
    chk("stall_valid", {63'h0, if_to_id_valid}, 64'h1);
    chk("stall_en",    {63'h0, inst_sram_en},   64'h0);
    chk("stall_bus",   if_to_id_bus, {32'h00000004, 32'h00000004});
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, if_to_id_valid}, 64'h0);
    chk("async_rst_en",    {63'h0, inst_sram_en},   64'h0);
    chk("async_rst_pc",    {32'h0, if_to_id_bus[63:32]}, {32'h0, 32'h1bfffffc});
    $display("[TB] async reset: vld=%0b en=%0b", if_to_id_valid, inst_sram_en);
    repeat (2) @(posedge clk);
    #1;
    resetn     = 1'b1;
    id_allowin = 1'b1;
    #3;
    chk("restart_en",    {63'h0, inst_sram_en},   64'h1);
    chk("restart_addr",  {32'h0, inst_sram_addr}, {32'h0, 32'h1c000000});
    chk("restart_valid", {63'h0, if_to_id_valid}, 64'h0);
    @(posedge clk);
    #4;
    chk("restart_bus",   if_to_id_bus, {32'h1c000000, 32'h1c000000});
    chk("restart_valid2", {63'h0, if_to_id_valid}, 64'h1);
    $display("[TB] restart: vld=%0b bus=%h", if_to_id_valid, if_to_id_bus);

`ifdef IF_ADEF_CHECK_EN
    // Redirect to a misaligned target: no SRAM access, NOP with adef in IF.
    @(posedge clk);
    #1;
    id_to_if_bus = {1'b1, 32'h1c000102};
    #3;
    chk("adef_en",    {63'h0, inst_sram_en},   64'h0);
    chk("adef_addr",  {32'h0, inst_sram_addr}, {32'h0, 32'h1c000102});
    chk("adef_valid0", {63'h0, if_to_id_valid}, 64'h0);
    @(posedge clk);
    #1;
    id_to_if_bus = 33'h0;
    #3;
    chk("adef_flag",  {63'h0, if_adef},        64'h1);
    chk("adef_valid", {63'h0, if_to_id_valid}, 64'h1);
    chk("adef_bus",   if_to_id_bus, {32'h1c000102, 32'h03400000});
    chk("adef_en2",   {63'h0, inst_sram_en},   64'h0);
    $display("[TB] adef: flag=%0b bus=%h en=%0b", if_adef, if_to_id_bus, inst_sram_en);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
